// File: rtl/seqdet_ctx_sched.sv
// seqdet_ctx_sched: one shared 4-state bit-sequence detector time-shared
// across NCH requester channels. Each channel keeps a 2-bit saved detector
// state so that a bit stream split across words is tracked continuously.
// A round-robin arbiter picks a channel in IDLE, the word is shifted
// MSB-first through the detector for W cycles, and a one-cycle DONE pulse
// reports hit count and final state before writing the context back.
module seqdet_ctx_sched #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req_valid,
  input  logic [NCH*W-1:0] req_data,
  output logic [NCH-1:0]   req_ready,
  input  logic             clr_ctx,
  output logic             done_valid,
  output logic [1:0]       done_ch,
  output logic [3:0]       done_hits,
  output logic [1:0]       done_state,
  output logic             busy
);

  // Channel index width; NCH is a power of two here, so index arithmetic
  // wraps naturally mod NCH.
  localparam int PW = $clog2(NCH);
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} fsm_t;

  fsm_t                  fsm_q;
  logic [PW-1:0]         p_q;
  logic [W-1:0]          word_q;
  logic [1:0]            st_q;
  logic [PW-1:0]         ch_q;
  logic [3:0]            hits_q;
  logic [CW-1:0]         bcnt_q;
  logic [NCH-1:0][1:0]   ctx_q;

  logic                  done_valid_q;
  logic [1:0]            done_ch_q;
  logic [3:0]            done_hits_q;
  logic [1:0]            done_state_q;

  logic                  gnt_any;
  logic [PW-1:0]         gnt_idx;
  logic [PW-1:0]         srch_idx;
  logic [W-1:0]          gnt_word;

  logic [1:0]            st_d;
  logic [3:0]            hits_d;
  logic                  last_bit;

  // Round-robin search: walk offsets high to low so the lowest offset from
  // p_q that has a valid request is the one left standing.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    srch_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      srch_idx = p_q + PW'(i);
      if (req_valid[srch_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = srch_idx;
      end
    end
  end

  assign gnt_word = req_data[gnt_idx*W +: W];

  // Ready only toward the winner and only while idle.
  always_comb begin
    req_ready = '0;
    if (fsm_q == IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  // Detector step for the current MSB; a hit is scored off the pre-bit state.
  always_comb begin
    st_d = S0;
    if (word_q[W-1]) st_d = (st_q == S3) ? S3 : st_q + 2'd1;
    hits_d   = hits_q + {3'b000, (st_q == S2)};
    last_bit = (bcnt_q == CW'(W - 1));
  end

  // Control FSM: IDLE accepts, SHIFT walks W bits, DONE reports for a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= IDLE;
      p_q          <= '0;
      word_q       <= '0;
      st_q         <= S0;
      ch_q         <= '0;
      hits_q       <= '0;
      bcnt_q       <= '0;
      done_valid_q <= 1'b0;
      done_ch_q    <= '0;
      done_hits_q  <= '0;
      done_state_q <= S0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (gnt_any) begin
            word_q <= gnt_word;
            st_q   <= ctx_q[gnt_idx];
            ch_q   <= gnt_idx;
            hits_q <= '0;
            bcnt_q <= '0;
            p_q    <= gnt_idx + PW'(1);
            fsm_q  <= SHIFT;
          end
        end
        SHIFT: begin
          word_q <= word_q << 1;
          st_q   <= st_d;
          hits_q <= hits_d;
          bcnt_q <= bcnt_q + CW'(1);
          if (last_bit) begin
            // Results are latched here so they are stable for the DONE cycle
            // and then hold until the next word finishes.
            fsm_q        <= DONE;
            done_valid_q <= 1'b1;
            done_ch_q    <= 2'(ch_q);
            done_hits_q  <= hits_d;
            done_state_q <= st_d;
          end
        end
        DONE: begin
          done_valid_q <= 1'b0;
          fsm_q        <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  // Saved contexts: clear beats the DONE writeback when both hit one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ctx_q <= '0;
    else if (clr_ctx)        ctx_q <= '0;
    else if (fsm_q == DONE)  ctx_q[ch_q] <= done_state_q;
  end

  assign done_valid = done_valid_q;
  assign done_ch    = done_ch_q;
  assign done_hits  = done_hits_q;
  assign done_state = done_state_q;
  assign busy       = (fsm_q != IDLE);

endmodule

// File: tb/tb_seqdet_ctx_sched.sv
// Bench for seqdet_ctx_sched: table of words with hand-derived results fed
// through a scoreboard queue, plus directed round-robin, clear and reset
// sequences.
module tb_seqdet_ctx_sched;
  localparam int NCH = 4;
  localparam int W   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   req_valid;
  logic [NCH*W-1:0] req_data;
  logic [NCH-1:0]   req_ready;
  logic             clr_ctx;
  logic             done_valid;
  logic [1:0]       done_ch;
  logic [3:0]       done_hits;
  logic [1:0]       done_state;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
    logic [3:0] hits;
    logic [1:0] st;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[11];
  vec_t rr_exp[5];

  seqdet_ctx_sched #(.NCH(NCH), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .clr_ctx    (clr_ctx),
    .done_valid (done_valid),
    .done_ch    (done_ch),
    .done_hits  (done_hits),
    .done_state (done_state),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding word.
  always @(negedge clk) begin
    vec_t e;
    if (rst_n === 1'b1 && done_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_done", done_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("done_ch",    done_ch,    e.ch);
        chk("done_hits",  done_hits,  e.hits);
        chk("done_state", done_state, e.st);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Offer one word on channel ch, wait for its grant, check latency and
  // the held outputs afterwards. clr_at pulses clr_ctx in that cycle
  // after accept (8 = the DONE cycle); -1 means no clear.
  task automatic send(input int ch, input logic [7:0] d, input logic [3:0] eh,
                      input logic [1:0] es, input int clr_at);
    int  k;
    bit  got;
    logic [NCH-1:0] oh;
    got = 1'b0;
    req_data[ch*W +: W] = d;
    req_valid[ch] = 1'b1;
    for (k = 0; k < 40; k++) begin
      #2;
      if (req_ready[ch]) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("grant_seen", got, 1);
    if (!got) begin req_valid[ch] = 1'b0; return; end
    oh = '0; oh[ch] = 1'b1;
    chk("ready_onehot", req_ready, oh);
    exp_q.push_back('{2'(ch), d, eh, es});
    @(posedge clk); #1;
    req_valid[ch] = 1'b0;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      clr_ctx = (k == clr_at);
      if (done_valid) break;
    end
    chk("latency", k, 8);
    @(posedge clk); #1;
    clr_ctx = 1'b0;
    chk("pulse_1cyc", done_valid, 0);
    chk("hold_hits",  done_hits,  eh);
    chk("hold_state", done_state, es);
    chk("busy_idle",  busy,       0);
  endtask

  initial begin
    int ngr, last_c, gch;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    clr_ctx   = 1'b0;

    // Words from a fresh reset; context carries per channel.
    tbl[0]  = '{2'd0, 8'hFF, 4'd1, 2'd3};
    tbl[1]  = '{2'd1, 8'hDB, 4'd2, 2'd2};
    tbl[2]  = '{2'd1, 8'h00, 4'd1, 2'd0};
    tbl[3]  = '{2'd0, 8'h00, 4'd0, 2'd0};
    tbl[4]  = '{2'd3, 8'h55, 4'd0, 2'd1};
    tbl[5]  = '{2'd3, 8'hFF, 4'd1, 2'd3};
    tbl[6]  = '{2'd2, 8'h6C, 4'd2, 2'd0};
    tbl[7]  = '{2'd2, 8'hB6, 4'd2, 2'd0};
    tbl[8]  = '{2'd2, 8'h03, 4'd0, 2'd2};
    tbl[9]  = '{2'd2, 8'hFF, 4'd1, 2'd3};
    tbl[10] = '{2'd0, 8'h92, 4'd0, 2'd0};

    rr_exp[0] = '{2'd0, 8'hFF, 4'd1, 2'd3};
    rr_exp[1] = '{2'd1, 8'hDB, 4'd2, 2'd2};
    rr_exp[2] = '{2'd2, 8'h03, 4'd0, 2'd2};
    rr_exp[3] = '{2'd3, 8'h55, 4'd0, 2'd1};
    rr_exp[4] = '{2'd0, 8'hFF, 4'd0, 2'd3};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_ch",    done_ch,    0);
    chk("rst_done_hits",  done_hits,  0);
    chk("rst_done_state", done_state, 0);
    chk("rst_busy",       busy,       0);
    chk("rst_ready",      req_ready,  0);
    rst_n = 1'b1;

    // Round robin with all channels requesting continuously.
    req_data  = {8'h55, 8'h03, 8'hDB, 8'hFF};
    req_valid = 4'hF;
    ngr = 0; last_c = 0;
    for (int c = 0; c < 80 && ngr < 5; c++) begin
      #2;
      if (busy) chk("ready_zero_busy", req_ready, 0);
      else begin
        chk("ready_count", $countones(req_ready), 1);
        gch = 0;
        for (int j = 0; j < NCH; j++) if (req_ready[j]) gch = j;
        chk("rr_order", gch, ngr % 4);
        if (ngr > 0) chk("rr_spacing", c - last_c, 10);
        exp_q.push_back(rr_exp[ngr]);
        last_c = c;
        ngr++;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    chk("rr_grants", ngr, 5);
    for (int c = 0; c < 30 && busy; c++) begin @(posedge clk); #1; end
    chk("rr_drained", exp_q.size(), 0);

    // Table-driven words from a fresh reset
    do_reset();
    for (int i = 0; i < 11; i++)
      send(int'(tbl[i].ch), tbl[i].data, tbl[i].hits, tbl[i].st, -1);

    // Clear while idle wipes a carried S2
    send(2, 8'h03, 4'd0, 2'd2, -1);
    clr_ctx = 1'b1; @(posedge clk); #1; clr_ctx = 1'b0;
    send(2, 8'h00, 4'd0, 2'd0, -1);

    // Clear coincident with DONE writeback wins
    send(2, 8'h03, 4'd0, 2'd2, 8);
    send(2, 8'h00, 4'd0, 2'd0, -1);

    // Clear mid-shift leaves in-flight word alone; its writeback lands after
    send(1, 8'h03, 4'd0, 2'd2, 3);
    send(1, 8'h00, 4'd1, 2'd0, -1);

    // Reset during the 4th SHIFT cycle discards the word
    send(2, 8'h03, 4'd0, 2'd2, -1);
    req_data[2*W +: W] = 8'h0F;
    req_valid[2] = 1'b1;
    #2;
    chk("abort_ready", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy",       busy,       0);
    chk("arst_done_valid", done_valid, 0);
    chk("arst_done_ch",    done_ch,    0);
    chk("arst_done_state", done_state, 0);
    chk("arst_done_hits",  done_hits,  0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", done_valid, 0);
    end
    req_data  = {8'h00, 8'hFF, 8'h00, 8'h00};
    req_valid = 4'hF;
    #2;
    chk("grant_ptr_reset", req_ready, 4'b0001);
    req_valid = 4'b0100;
    #1;
    send(2, 8'hFF, 4'd1, 2'd3, -1);

    repeat (4) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
